pe_result_drain: RTL and testbench

- Reader side of the processing-element result interface.
- Snapshots the 2*WIDTH-bit Result outputs of one row of COLS processing elements on a capture strobe.
- Serializes the snapshot to a downstream consumer (output buffer / memory writer) over a valid/ready stream.
- Supports zero-bubble back-to-back captures and flags captures it has to drop.

---
 rtl/pe_result_drain_if.sv | 28 ++
 rtl/pe_result_drain.sv | 82 ++++++++
 tb/tb_pe_result_drain.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pe_result_drain_if.sv
// rtl/pe_result_drain_if.sv - capture and result-stream signals of the PE result drain
interface pe_result_drain_if #(
  parameter int WIDTH = 8,
  parameter int COLS  = 4,
  parameter int IDXW  = (COLS > 1) ? $clog2(COLS) : 1
);
  logic                    CAPTURE;
  logic [COLS*2*WIDTH-1:0] ResultsIn;
  logic                    Busy;
  logic [2*WIDTH-1:0]      OutData;
  logic [IDXW-1:0]         OutIndex;
  logic                    OutLast;
  logic                    OutValid;
  logic                    OutReady;
  logic                    Overrun;

  // drain side: takes the PE row snapshot, drives the stream
  modport master (
    input  CAPTURE, ResultsIn, OutReady,
    output Busy, OutData, OutIndex, OutLast, OutValid, Overrun
  );

  // producer/consumer side
  modport slave (
    output CAPTURE, ResultsIn, OutReady,
    input  Busy, OutData, OutIndex, OutLast, OutValid, Overrun
  );
endinterface

// File: rtl/pe_result_drain.sv
// rtl/pe_result_drain.sv - snapshots a PE result row and serializes it onto a valid/ready stream
module pe_result_drain #(
  parameter int WIDTH = 8,
  parameter int COLS  = 4
) (
  input logic          CLK,
  input logic          SYNC_RST,
  pe_result_drain_if.master bus
);
  localparam int IDXW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW   = 2 * WIDTH;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(COLS - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   buf_q [COLS];
  logic [IDXW-1:0] idx_q;
  logic            ovr_q;

  logic at_last;
  logic xfer;
  logic final_xfer;
  logic load;

  assign at_last    = (idx_q == LAST_IDX);
  assign xfer       = (state_q == DRAIN) && bus.OutReady;
  assign final_xfer = xfer && at_last;
  // A capture is accepted when idle or exactly on the last word's transfer,
  // which chains snapshots without a bubble; any other capture is dropped.
  assign load       = bus.CAPTURE && ((state_q == IDLE) || final_xfer);

  // State register
  always_ff @(posedge CLK) begin
    if (SYNC_RST) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.CAPTURE) state_d = DRAIN;
      DRAIN:   if (final_xfer && !bus.CAPTURE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Snapshot buffer, column index and sticky overrun flag
  always_ff @(posedge CLK) begin
    if (SYNC_RST) begin
      for (int c = 0; c < COLS; c++) buf_q[c] <= '0;
      idx_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (load) begin
        for (int c = 0; c < COLS; c++) buf_q[c] <= bus.ResultsIn[c*RW +: RW];
        idx_q <= '0;
      end else if (xfer && !at_last) begin
        idx_q <= idx_q + 1'b1;
      end
      if (bus.CAPTURE && !load) ovr_q <= 1'b1;
    end
  end

  // Stream outputs; data, index and last read as zero while idle
  always_comb begin
    bus.Busy     = 1'b0;
    bus.OutValid = 1'b0;
    bus.OutData  = '0;
    bus.OutIndex = '0;
    bus.OutLast  = 1'b0;
    bus.Overrun  = ovr_q;
    if (state_q == DRAIN) begin
      bus.Busy     = 1'b1;
      bus.OutValid = 1'b1;
      bus.OutData  = buf_q[idx_q];
      bus.OutIndex = idx_q;
      bus.OutLast  = at_last;
    end
  end
endmodule

// File: tb/tb_pe_result_drain.sv
// tb/tb_pe_result_drain.sv - directed vector table plus randomized queue-model check of pe_result_drain
module tb_pe_result_drain;
  localparam int WIDTH = 8;
  localparam int COLS  = 4;
  localparam logic [63:0] D1 = 64'h0004_0003_0002_0001;
  localparam logic [63:0] D2 = 64'hFFFF_8000_00FF_1234;
  localparam logic [21:0] IDLE_MASK = 22'h3C0000;

  logic CLK = 1'b0;
  logic SYNC_RST;

  pe_result_drain_if #(.WIDTH(WIDTH), .COLS(COLS)) bus ();

  pe_result_drain #(.WIDTH(WIDTH), .COLS(COLS)) dut (
    .CLK      (CLK),
    .SYNC_RST (SYNC_RST),
    .bus      (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        rst;
    logic        cap;
    logic        ready;
    logic [63:0] data;
    logic [21:0] exp;
  } vec_t;

  vec_t tbl [28];
  int   n_vec = 0;
  int   n_bad = 0;

  // model state: words still to be streamed, and the sticky overrun flag
  logic [15:0] q [$];
  bit          m_ovr;

  // packed view {Busy, OutValid, OutLast, Overrun, OutIndex, OutData}
  function automatic logic [21:0] ex(bit v, bit l, bit o, logic [1:0] i, logic [15:0] d);
    return {v, v, l, o, i, d};
  endfunction

  function automatic logic [21:0] actual();
    return {bus.Busy, bus.OutValid, bus.OutLast, bus.Overrun, bus.OutIndex, bus.OutData};
  endfunction

  function automatic logic [21:0] model_out();
    logic [21:0] r;
    if (q.size() == 0) r = ex(1'b0, 1'b0, m_ovr, 2'd0, 16'h0);
    else r = ex(1'b1, q.size() == 1, m_ovr, 2'(COLS - q.size()), q[0]);
    return r;
  endfunction

  task automatic model_edge(input bit rst, input bit cap, input bit ready, input logic [63:0] data);
    bit had, xfer;
    if (rst) begin
      q.delete();
      m_ovr = 1'b0;
    end else begin
      had  = (q.size() != 0);
      xfer = had && ready;
      if (xfer) void'(q.pop_front());
      if (cap) begin
        if (!had || (xfer && q.size() == 0))
          for (int c = 0; c < COLS; c++) q.push_back(data[c*16 +: 16]);
        else
          m_ovr = 1'b1;
      end
    end
  endtask

  task automatic drive(input bit rst, input bit cap, input bit ready, input logic [63:0] data);
    SYNC_RST      = rst;
    bus.CAPTURE   = cap;
    bus.OutReady  = ready;
    bus.ResultsIn = data;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int k, input bit full, input logic [21:0] exp);
    logic [21:0] m, a;
    m = (full || exp[20]) ? 22'h3FFFFF : IDLE_MASK;
    a = actual();
    n_vec++;
    if ((a & m) !== (exp & m)) begin
      n_bad++;
      $display("FAIL %s %0d: got busy/valid/last/ovr/idx/data=%0b/%0b/%0b/%0b/%0d/%h expected %0b/%0b/%0b/%0b/%0d/%h",
               name, k, a[21], a[20], a[19], a[18], a[17:16], a[15:0],
               exp[21], exp[20], exp[19], exp[18], exp[17:16], exp[15:0]);
    end
  endtask

  initial begin
    logic [63:0] rd;
    bit          r_rst, r_cap, r_rdy;

    SYNC_RST = 1'b1; bus.CAPTURE = 1'b0; bus.OutReady = 1'b0; bus.ResultsIn = '0;

    // reset, idle with ready toggling, basic drain with backpressure on index 1
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 64'h0, ex(0, 0, 0, 2'd0, 16'h0000)};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, D1,    ex(0, 0, 0, 2'd0, 16'h0000)};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, D1,    ex(0, 0, 0, 2'd0, 16'h0000)};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, D1,    ex(1, 0, 0, 2'd0, 16'h0001)};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, D1,    ex(1, 0, 0, 2'd1, 16'h0002)};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, D1,    ex(1, 0, 0, 2'd1, 16'h0002)};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, D1,    ex(1, 0, 0, 2'd1, 16'h0002)};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, D1,    ex(1, 0, 0, 2'd1, 16'h0002)};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, D1,    ex(1, 0, 0, 2'd2, 16'h0003)};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, D1,    ex(1, 1, 0, 2'd3, 16'h0004)};
    // back-to-back capture on the final transfer
    tbl[10] = '{1'b0, 1'b1, 1'b1, D2,    ex(1, 0, 0, 2'd0, 16'h1234)};
    tbl[11] = '{1'b0, 1'b0, 1'b1, D1,    ex(1, 0, 0, 2'd1, 16'h00FF)};
    tbl[12] = '{1'b0, 1'b0, 1'b1, D1,    ex(1, 0, 0, 2'd2, 16'h8000)};
    tbl[13] = '{1'b0, 1'b0, 1'b1, D1,    ex(1, 1, 0, 2'd3, 16'hFFFF)};
    tbl[14] = '{1'b0, 1'b0, 1'b1, D1,    ex(0, 0, 0, 2'd0, 16'h0000)};
    // overrun: capture while index 1 is stalled
    tbl[15] = '{1'b0, 1'b1, 1'b1, D1,    ex(1, 0, 0, 2'd0, 16'h0001)};
    tbl[16] = '{1'b0, 1'b0, 1'b1, D1,    ex(1, 0, 0, 2'd1, 16'h0002)};
    tbl[17] = '{1'b0, 1'b1, 1'b0, D2,    ex(1, 0, 1, 2'd1, 16'h0002)};
    tbl[18] = '{1'b0, 1'b0, 1'b1, D2,    ex(1, 0, 1, 2'd2, 16'h0003)};
    tbl[19] = '{1'b0, 1'b0, 1'b1, D2,    ex(1, 1, 1, 2'd3, 16'h0004)};
    tbl[20] = '{1'b0, 1'b0, 1'b1, D2,    ex(0, 0, 1, 2'd0, 16'h0000)};
    tbl[21] = '{1'b0, 1'b1, 1'b1, D2,    ex(1, 0, 1, 2'd0, 16'h1234)};
    tbl[22] = '{1'b0, 1'b0, 1'b1, D1,    ex(1, 0, 1, 2'd1, 16'h00FF)};
    tbl[23] = '{1'b0, 1'b0, 1'b1, D1,    ex(1, 0, 1, 2'd2, 16'h8000)};
    // reset mid-drain, then a fresh capture
    tbl[24] = '{1'b1, 1'b0, 1'b1, D1,    ex(0, 0, 0, 2'd0, 16'h0000)};
    tbl[25] = '{1'b0, 1'b0, 1'b1, D1,    ex(0, 0, 0, 2'd0, 16'h0000)};
    tbl[26] = '{1'b0, 1'b1, 1'b1, D1,    ex(1, 0, 0, 2'd0, 16'h0001)};
    tbl[27] = '{1'b0, 1'b0, 1'b1, D1,    ex(1, 0, 0, 2'd1, 16'h0002)};

    for (int i = 0; i < 28; i++) begin
      drive(tbl[i].rst, tbl[i].cap, tbl[i].ready, tbl[i].data);
      check("table", i, tbl[i].rst, tbl[i].exp);
    end

    // randomized traffic against the queue model
    drive(1'b1, 1'b0, 1'b0, 64'h0);
    model_edge(1'b1, 1'b0, 1'b0, 64'h0);
    check("rand_reset", 0, 1'b1, model_out());
    for (int i = 0; i < 600; i++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      r_cap = ($urandom_range(0, 5) == 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      rd    = {$urandom, $urandom};
      drive(r_rst, r_cap, r_rdy, rd);
      model_edge(r_rst, r_cap, r_rdy, rd);
      check("random", i, r_rst, model_out());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
